spi_master: RTL and testbench

Single-channel SPI bus master that shifts a DATA_WIDTH-bit word out on mosi while capturing DATA_WIDTH bits from miso, MSB first. It generates sck from the system clock by a power-of-two divider and reports completion with a one-cycle new_data strobe. In the acquisition path it reads the dual-channel ADC result word (36 bits, two 18-bit channels) after each conversion.

---
 rtl/spi_master.sv | 136 +++++++++++++
 tb/tb_spi_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Brief    : Single-channel SPI master, MSB first, sck = clk / 2^CLK_DIV.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int CLK_DIV    = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sck,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  new_data
);

    localparam int c_bit_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_wait_half = 2'd1;
    localparam logic [1:0] c_transfer  = 2'd2;

    localparam logic [CLK_DIV-1:0] c_half_last   = {1'b0, {(CLK_DIV-1){1'b1}}};
    localparam logic [CLK_DIV-1:0] c_period_last = {CLK_DIV{1'b1}};
    localparam logic [c_bit_w-1:0] c_last_bit    = c_bit_w'(DATA_WIDTH - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [CLK_DIV-1:0]    r_cnt;
    logic [c_bit_w-1:0]    r_bit_ctr;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_mosi;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_new_data;

    logic w_accept;
    logic w_launch;
    logic w_capture;
    logic w_bit_end;
    logic w_done;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_launch     = 1'b0;
        w_capture    = 1'b0;
        w_bit_end    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_wait_half;
                end
            end
            c_wait_half: begin
                if (r_cnt == c_half_last) begin
                    w_state_next = c_transfer;
                end
            end
            c_transfer: begin
                w_launch  = (r_cnt == '0);
                w_capture = (r_cnt == c_half_last);
                w_bit_end = (r_cnt == c_period_last);
                if (w_bit_end && (r_bit_ctr == c_last_bit)) begin
                    w_done       = 1'b1;
                    w_state_next = c_idle;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter restarts at the WAIT_HALF -> TRANSFER handoff so sck rises on cnt 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == c_idle) ||
                     ((r_state == c_wait_half) && (r_cnt == c_half_last))) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_ctr  <= '0;
            r_shift    <= '0;
            r_mosi     <= 1'b0;
            r_data_out <= '0;
            r_new_data <= 1'b0;
        end else begin
            r_new_data <= 1'b0;
            if (w_accept) begin
                r_shift   <= data_in;
                r_bit_ctr <= '0;
            end
            if (w_launch) begin
                r_mosi <= r_shift[DATA_WIDTH-1];
            end
            if (w_capture) begin
                r_shift <= {r_shift[DATA_WIDTH-2:0], miso};
            end
            if (w_bit_end) begin
                r_bit_ctr <= r_bit_ctr + 1'b1;
            end
            if (w_done) begin
                r_data_out <= r_shift;
                r_new_data <= 1'b1;
            end
        end
    end

    assign sck      = (r_state == c_transfer) & ~r_cnt[CLK_DIV-1];
    assign busy     = (r_state != c_idle);
    assign mosi     = r_mosi;
    assign data_out = r_data_out;
    assign new_data = r_new_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Brief    : Directed self-checking bench for spi_master (ADC and loopback).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic        clk = 1'b0;
    logic        r_rst = 1'b1;

    logic        r_start_a = 1'b0;
    logic [35:0] r_data_in_a = '0;
    logic        w_miso_a;
    logic        w_mosi_a, w_sck_a, w_busy_a, w_new_data_a;
    logic [35:0] w_data_out_a;

    logic        r_start_lb = 1'b0;
    logic [7:0]  r_data_in_lb = '0;
    logic        r_lb_loop = 1'b0;
    logic        r_lb_miso = 1'b0;
    logic        w_miso_lb;
    logic        w_mosi_lb, w_sck_lb, w_busy_lb, w_new_data_lb;
    logic [7:0]  w_data_out_lb;

    logic [35:0] r_slave_word = '0;
    logic [35:0] r_slave_reg = '0;
    logic        r_slave_miso = 1'b0;
    logic        r_slave_load = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(2), .DATA_WIDTH(36)) dut_adc (
        .clk(clk), .rst(r_rst), .start(r_start_a), .data_in(r_data_in_a),
        .miso(w_miso_a), .mosi(w_mosi_a), .sck(w_sck_a),
        .data_out(w_data_out_a), .busy(w_busy_a), .new_data(w_new_data_a)
    );

    spi_master #(.CLK_DIV(3), .DATA_WIDTH(8)) dut_lb (
        .clk(clk), .rst(r_rst), .start(r_start_lb), .data_in(r_data_in_lb),
        .miso(w_miso_lb), .mosi(w_mosi_lb), .sck(w_sck_lb),
        .data_out(w_data_out_lb), .busy(w_busy_lb), .new_data(w_new_data_lb)
    );

    assign w_miso_a  = r_slave_miso;
    assign w_miso_lb = r_lb_loop ? w_mosi_lb : r_lb_miso;

    // ADC slave: launches its MSB on every sck rise.
    always @(posedge w_sck_a or posedge r_slave_load) begin
        if (r_slave_load) begin
            r_slave_reg  <= r_slave_word;
            r_slave_miso <= 1'b0;
        end else begin
            {r_slave_miso, r_slave_reg} <= {r_slave_reg, 1'b0};
        end
    end

    logic        r_sel = 1'b0;
    logic        w_m_busy, w_m_sck, w_m_mosi, w_m_nd;
    logic [35:0] w_m_data;
    assign w_m_busy = r_sel ? w_busy_lb     : w_busy_a;
    assign w_m_sck  = r_sel ? w_sck_lb      : w_sck_a;
    assign w_m_mosi = r_sel ? w_mosi_lb     : w_mosi_a;
    assign w_m_nd   = r_sel ? w_new_data_lb : w_new_data_a;
    assign w_m_data = r_sel ? {28'd0, w_data_out_lb} : w_data_out_a;

    int          mon_busy, mon_rises, mon_period, mon_nd;
    bit          mon_timeout, mon_end_nd, mon_after_nd, mon_after_busy;
    logic [63:0] mon_mosi;
    logic [35:0] mon_data, mon_after_data;

    task automatic load_slave(input logic [35:0] word);
        r_slave_word = word;
        r_slave_load = 1'b1;
        #1;
        r_slave_load = 1'b0;
    endtask

    task automatic set_start(input bit sel, input logic val);
        if (sel) r_start_lb = val;
        else     r_start_a  = val;
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
    endtask

    // Gathers transfer statistics from the negedge right after the accepting edge.
    task automatic monitor(input bit sel, input int poke_at);
        int  i;
        int  first_rise;
        bit  prev_sck;
        r_sel = sel;
        #0;
        mon_busy = 0; mon_rises = 0; mon_period = 0; mon_nd = 0;
        mon_timeout = 1'b0; mon_mosi = '0;
        first_rise = -1; prev_sck = 1'b0;
        for (i = 0; i < 2000; i++) begin
            if (!w_m_busy) break;
            mon_busy++;
            if (w_m_sck && !prev_sck) begin
                mon_rises++;
                if (first_rise < 0) first_rise = i;
                else if (mon_period == 0) mon_period = i - first_rise;
            end
            if (!w_m_sck && prev_sck) mon_mosi = {mon_mosi[62:0], w_m_mosi};
            if (w_m_nd) mon_nd++;
            prev_sck = w_m_sck;
            set_start(sel, (i == poke_at) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        set_start(sel, 1'b0);
        if (i == 2000) mon_timeout = 1'b1;
        mon_end_nd = w_m_nd;
        mon_data   = w_m_data;
        @(negedge clk);
        mon_after_nd   = w_m_nd;
        mon_after_busy = w_m_busy;
        mon_after_data = w_m_data;
    endtask

    task automatic test_reset;
        @(negedge clk);
        r_rst = 1'b1;
        repeat (3) @(negedge clk);
        r_rst = 1'b0;
        @(negedge clk);
        n_checks += 10;
        if (w_sck_a !== 1'b0)      begin n_errors++; $display("FAIL rst_sck_a: got %b expected 0", w_sck_a); end
        if (w_mosi_a !== 1'b0)     begin n_errors++; $display("FAIL rst_mosi_a: got %b expected 0", w_mosi_a); end
        if (w_busy_a !== 1'b0)     begin n_errors++; $display("FAIL rst_busy_a: got %b expected 0", w_busy_a); end
        if (w_new_data_a !== 1'b0) begin n_errors++; $display("FAIL rst_nd_a: got %b expected 0", w_new_data_a); end
        if (w_data_out_a !== 36'h0) begin n_errors++; $display("FAIL rst_data_a: got %h expected 0", w_data_out_a); end
        if (w_sck_lb !== 1'b0)      begin n_errors++; $display("FAIL rst_sck_lb: got %b expected 0", w_sck_lb); end
        if (w_mosi_lb !== 1'b0)     begin n_errors++; $display("FAIL rst_mosi_lb: got %b expected 0", w_mosi_lb); end
        if (w_busy_lb !== 1'b0)     begin n_errors++; $display("FAIL rst_busy_lb: got %b expected 0", w_busy_lb); end
        if (w_new_data_lb !== 1'b0) begin n_errors++; $display("FAIL rst_nd_lb: got %b expected 0", w_new_data_lb); end
        if (w_data_out_lb !== 8'h0) begin n_errors++; $display("FAIL rst_data_lb: got %h expected 0", w_data_out_lb); end
    endtask

    task automatic test_adc_read;
        load_slave(36'h0_0000_0001);
        r_data_in_a = 36'hC_3A5F_0916;
        pulse_start(1'b0);
        monitor(1'b0, -1);
        n_checks += 9;
        if (mon_timeout)          begin n_errors++; $display("FAIL adc_timeout: transfer did not finish"); end
        if (mon_busy != 146)      begin n_errors++; $display("FAIL adc_busy_cycles: got %0d expected 146", mon_busy); end
        if (mon_rises != 36)      begin n_errors++; $display("FAIL adc_sck_rises: got %0d expected 36", mon_rises); end
        if (mon_period != 4)      begin n_errors++; $display("FAIL adc_sck_period: got %0d expected 4", mon_period); end
        if (mon_nd != 0 || mon_end_nd !== 1'b1 || mon_after_nd !== 1'b0)
            begin n_errors++; $display("FAIL adc_new_data: during=%0d end=%b after=%b expected 0/1/0", mon_nd, mon_end_nd, mon_after_nd); end
        if (mon_data !== 36'h0_0000_0001)
            begin n_errors++; $display("FAIL adc_data_out: got %h expected 000000001", mon_data); end
        if (mon_after_data !== 36'h0_0000_0001)
            begin n_errors++; $display("FAIL adc_data_hold: got %h expected 000000001", mon_after_data); end
        if (mon_mosi[35:0] !== 36'hC_3A5F_0916)
            begin n_errors++; $display("FAIL adc_mosi_bits: got %h expected c3a5f0916", mon_mosi[35:0]); end
        if (mon_after_busy !== 1'b0)
            begin n_errors++; $display("FAIL adc_idle_after: got busy=%b expected 0", mon_after_busy); end
    endtask

    task automatic test_loopback;
        r_lb_loop    = 1'b1;
        r_data_in_lb = 8'hA5;
        pulse_start(1'b1);
        monitor(1'b1, -1);
        n_checks += 6;
        if (mon_timeout)        begin n_errors++; $display("FAIL lb_timeout: transfer did not finish"); end
        if (mon_busy != 68)     begin n_errors++; $display("FAIL lb_busy_cycles: got %0d expected 68", mon_busy); end
        if (mon_period != 8)    begin n_errors++; $display("FAIL lb_sck_period: got %0d expected 8", mon_period); end
        if (mon_mosi[7:0] !== 8'hA5 || mon_rises != 8)
            begin n_errors++; $display("FAIL lb_mosi_wave: got %b (%0d rises) expected 10100101 (8)", mon_mosi[7:0], mon_rises); end
        if (mon_data[7:0] !== 8'hA5) begin n_errors++; $display("FAIL lb_data_out: got %h expected a5", mon_data[7:0]); end
        if (mon_nd != 0 || mon_end_nd !== 1'b1 || mon_after_nd !== 1'b0)
            begin n_errors++; $display("FAIL lb_new_data: during=%0d end=%b after=%b expected 0/1/0", mon_nd, mon_end_nd, mon_after_nd); end
    endtask

    task automatic test_start_ignored;
        load_slave(36'h8_0000_0003);
        r_data_in_a = 36'h0_FFFF_0000;
        pulse_start(1'b0);
        monitor(1'b0, 9);
        n_checks += 4;
        if (mon_busy != 146)   begin n_errors++; $display("FAIL ign_busy_cycles: got %0d expected 146", mon_busy); end
        if (mon_nd != 0 || mon_end_nd !== 1'b1 || mon_after_nd !== 1'b0)
            begin n_errors++; $display("FAIL ign_new_data: during=%0d end=%b after=%b expected 0/1/0", mon_nd, mon_end_nd, mon_after_nd); end
        if (mon_data !== 36'h8_0000_0003) begin n_errors++; $display("FAIL ign_data_out: got %h expected 800000003", mon_data); end
        if (mon_after_busy !== 1'b0) begin n_errors++; $display("FAIL ign_queued: got busy=%b expected 0", mon_after_busy); end
    endtask

    task automatic test_reset_mid;
        int nd_seen;
        load_slave(36'hF_FFFF_FFFF);
        pulse_start(1'b0);
        repeat (2 + 19 * 4 + 1) @(negedge clk);
        n_checks += 1;
        if (w_busy_a !== 1'b1) begin n_errors++; $display("FAIL mid_busy_before: got %b expected 1", w_busy_a); end
        r_rst = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (w_sck_a !== 1'b0)      begin n_errors++; $display("FAIL mid_sck: got %b expected 0", w_sck_a); end
        if (w_busy_a !== 1'b0)     begin n_errors++; $display("FAIL mid_busy: got %b expected 0", w_busy_a); end
        if (w_new_data_a !== 1'b0) begin n_errors++; $display("FAIL mid_nd: got %b expected 0", w_new_data_a); end
        if (w_data_out_a !== 36'h0) begin n_errors++; $display("FAIL mid_data: got %h expected 0", w_data_out_a); end
        if (w_mosi_a !== 1'b0)     begin n_errors++; $display("FAIL mid_mosi: got %b expected 0", w_mosi_a); end
        r_rst = 1'b0;
        nd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (w_new_data_a || w_busy_a) nd_seen++;
        end
        n_checks += 1;
        if (nd_seen != 0) begin n_errors++; $display("FAIL mid_quiet: got %0d active cycles expected 0", nd_seen); end
        load_slave(36'h9_8765_4321);
        pulse_start(1'b0);
        monitor(1'b0, -1);
        n_checks += 3;
        if (mon_busy != 146 || mon_rises != 36)
            begin n_errors++; $display("FAIL mid_retry_timing: busy=%0d rises=%0d expected 146/36", mon_busy, mon_rises); end
        if (mon_data !== 36'h9_8765_4321) begin n_errors++; $display("FAIL mid_retry_data: got %h expected 987654321", mon_data); end
        if (mon_end_nd !== 1'b1 || mon_nd != 0)
            begin n_errors++; $display("FAIL mid_retry_nd: end=%b during=%0d expected 1/0", mon_end_nd, mon_nd); end
    endtask

    task automatic test_back_to_back;
        int n;
        int i;
        r_lb_loop    = 1'b0;
        r_lb_miso    = 1'b1;
        r_data_in_lb = 8'h00;
        n = 0;
        @(negedge clk);
        r_start_lb = 1'b1;
        for (i = 0; i < 1000 && n < 3; i++) begin
            @(negedge clk);
            if (w_new_data_lb) begin
                n++;
                n_checks += 2;
                if (w_data_out_lb !== 8'hFF) begin n_errors++; $display("FAIL b2b_data_%0d: got %h expected ff", n, w_data_out_lb); end
                if (w_busy_lb !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_%0d: got busy=%b expected 0", n, w_busy_lb); end
                if (n == 3) r_start_lb = 1'b0;
                @(negedge clk);
                n_checks += 1;
                if (w_busy_lb !== ((n < 3) ? 1'b1 : 1'b0))
                    begin n_errors++; $display("FAIL b2b_restart_%0d: got busy=%b expected %b", n, w_busy_lb, (n < 3)); end
            end
        end
        r_start_lb = 1'b0;
        n_checks += 1;
        if (n != 3) begin n_errors++; $display("FAIL b2b_count: got %0d transfers expected 3", n); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        r_rst = 1'b0;
        test_reset;
        test_adc_read;
        test_loopback;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
